// File: rtl/fixed_point_pkg.sv
// Shared types and saturation helpers for the fixed-point divider.
// FSM state encoding plus signed-limit functions sized at a 64-bit ceiling.
package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SAT_W = 64;

  function automatic logic [SAT_W-1:0] sat_pos(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_neg(input int w);
    return ~sat_pos(w);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: trial subtract, select, shift.
// acc carries the dividend out of its MSB and the quotient into its LSB.
module divider_step #(
  parameter int N  = 16,
  parameter int BW = 8
) (
  input  logic [N-1:0]  acc_i,
  input  logic [BW-1:0] rem_i,
  input  logic [BW-1:0] dvs_i,
  output logic [N-1:0]  acc_o,
  output logic [BW-1:0] rem_o
);

  logic [BW:0] shf;
  logic [BW:0] diff;
  logic        qbit;

  // rem < dvs <= 2^(BW-1), so a borrow always shows up in diff's MSB
  always_comb begin
    shf   = {rem_i, acc_i[N-1]};
    diff  = shf - {1'b0, dvs_i};
    qbit  = ~diff[BW];
    rem_o = qbit ? diff[BW-1:0] : shf[BW-1:0];
    acc_o = {acc_i[N-2:0], qbit};
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider, one quotient bit per cycle.
// Define FIXED_POINT_DIVIDER_ROUND_EN for round-to-nearest (ties away from 0).
module fixed_point_divider
  import fixed_point_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int IN_SCALE  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow,
  output logic                        div_zero
);

  localparam int N  = A_WIDTH + IN_SCALE;
  localparam int CW = $clog2(N + 1);

  localparam logic [SAT_W-1:0] POS_LIM = sat_pos(OUT_WIDTH);
  localparam logic [SAT_W-1:0] NEG_LIM = POS_LIM + SAT_W'(1);

  localparam logic [OUT_WIDTH-1:0] OUT_MAX =
    OUT_WIDTH'(POS_LIM);
  localparam logic [OUT_WIDTH-1:0] OUT_MIN =
    OUT_WIDTH'(sat_neg(OUT_WIDTH));

  state_e state_q, state_d;

  logic [N-1:0]         acc_q, acc_d, step_acc;
  logic [B_WIDTH-1:0]   rem_q, rem_d, step_rem;
  logic [B_WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 neg_q, neg_d;
  logic                 dz_q, dz_d;
  logic                 ovf_q, ovf_d;
  logic                 dzo_q, dzo_d;
  logic                 rdy_q, rdy_d;

  logic [A_WIDTH-1:0]   a_abs;
  logic [B_WIDTH-1:0]   b_abs;
  logic [N:0]           mag;
  logic [SAT_W-1:0]     mag_w;
  logic                 sat;

  // unsigned magnitudes: -2^(W-1) maps to 2^(W-1) without wrapping
  assign a_abs = a[A_WIDTH-1] ? -a : a;
  assign b_abs = b[B_WIDTH-1] ? -b : b;

  divider_step #(
    .N  (N),
    .BW (B_WIDTH)
  ) u_step (
    .acc_i (acc_q),
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .acc_o (step_acc),
    .rem_o (step_rem)
  );

  always_comb begin
    mag = {1'b0, acc_q};
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    if ({rem_q, 1'b0} >= {1'b0, dvs_q}) begin
      mag = mag + (N+1)'(1);
    end
`endif
    mag_w = SAT_W'(mag);
    sat   = neg_q ? (mag_w > NEG_LIM) : (mag_w > POS_LIM);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    dzo_d   = dzo_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          acc_d   = N'(a_abs) << IN_SCALE;
          rem_d   = '0;
          dvs_d   = b_abs;
          cnt_d   = '0;
          neg_d   = a[A_WIDTH-1] ^ b[B_WIDTH-1];
          dz_d    = (b == '0);
          state_d = CALC;
        end
      end
      CALC: begin
        if (dz_q) begin
          out_d   = neg_q ? OUT_MIN : OUT_MAX;
          ovf_d   = 1'b0;
          dzo_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CW'(N)) begin
          ovf_d   = sat;
          dzo_d   = 1'b0;
          if (sat) begin
            out_d = neg_q ? OUT_MIN : OUT_MAX;
          end else begin
            out_d = OUT_WIDTH'(neg_q ? -mag_w : mag_w);
          end
          state_d = DONE;
        end else begin
          acc_d = step_acc;
          rem_d = step_rem;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      dzo_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      dzo_q   <= dzo_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign div_zero  = dzo_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider against an arithmetic model.
// Honours FIXED_POINT_DIVIDER_ROUND_EN when computing expected quotients.
module tb_fixed_point_divider;

  localparam int AW   = 16;
  localparam int BW   = 8;
  localparam int OW   = 16;
  localparam int SC   = 0;
  localparam int N    = AW + SC;
  localparam int MAXV = (1 << (OW - 1)) - 1;
  localparam int MINV = -(1 << (OW - 1));

  logic                 clk       = 1'b0;
  logic                 rst       = 1'b1;
  logic signed [AW-1:0] a         = '0;
  logic signed [BW-1:0] b         = '0;
  logic                 in_valid  = 1'b0;
  logic                 in_ready;
  logic signed [OW-1:0] out;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 overflow;
  logic                 div_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fixed_point_divider #(
    .A_WIDTH   (AW),
    .B_WIDTH   (BW),
    .OUT_WIDTH (OW),
    .IN_SCALE  (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  // reference: exact integer division of a*2^SC by b, then saturate
  function automatic void model(input int ia, input int ib,
                                output int q, output bit ov,
                                output bit dz);
    longint num, qq;
    num = longint'(ia) * (longint'(1) << SC);
    ov  = 1'b0;
    dz  = 1'b0;
    if (ib == 0) begin
      dz = 1'b1;
      q  = (ia >= 0) ? MAXV : MINV;
      return;
    end
    qq = num / ib;
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    begin
      longint r, ar, ab;
      r  = num % ib;
      ar = (r < 0) ? -r : r;
      ab = (ib < 0) ? -ib : ib;
      if (2 * ar >= ab) qq += ((num < 0) != (ib < 0)) ? -1 : 1;
    end
`endif
    if (qq > MAXV) begin
      qq = MAXV;
      ov = 1'b1;
    end else if (qq < MINV) begin
      qq = MINV;
      ov = 1'b1;
    end
    q = int'(qq);
  endfunction

  function automatic int rand_a();
    case ($urandom_range(0, 9))
      0:       return MINV;
      1:       return MAXV;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  function automatic int rand_b();
    case ($urandom_range(0, 9))
      0:       return 0;
      1:       return -128;
      2:       return -1;
      3:       return 1;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  // one full transaction: transfer, bounded wait, capture, accept
  task automatic do_op(input int ia, input int ib, output int q,
                       output bit ov, output bit dz,
                       output int lat, output bit to);
    int k;
    to = 1'b0;
    k  = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) to = 1'b1;
    a        = AW'(ia);
    b        = BW'(ib);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) to = 1'b1;
    q  = int'(out);
    ov = overflow;
    dz = div_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out !== '0) begin
      n_err++;
      $display("FAIL reset_out got=%0d exp=0", out);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    n_cmp++;
    if (overflow !== 1'b0 || div_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags got=%b%b exp=00", overflow, div_zero);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic run_check(input string nm, input int ia, input int ib);
    int q, eq, lat, el;
    bit ov, dz, eo, ed, to;
    do_op(ia, ib, q, ov, dz, lat, to);
    model(ia, ib, eq, eo, ed);
    el = (ib == 0) ? 1 : N + 1;
    n_cmp++;
    if (to) begin
      n_err++;
      $display("FAIL %s_timeout a=%0d b=%0d got=timeout exp=done",
               nm, ia, ib);
    end
    n_cmp++;
    if (q != eq) begin
      n_err++;
      $display("FAIL %s_out a=%0d b=%0d got=%0d exp=%0d",
               nm, ia, ib, q, eq);
    end
    n_cmp++;
    if (ov != eo || dz != ed) begin
      n_err++;
      $display("FAIL %s_flags a=%0d b=%0d got=ov%b dz%b exp=ov%b dz%b",
               nm, ia, ib, ov, dz, eo, ed);
    end
    n_cmp++;
    if (lat != el) begin
      n_err++;
      $display("FAIL %s_latency a=%0d b=%0d got=%0d exp=%0d",
               nm, ia, ib, lat, el);
    end
  endtask

  task automatic test_directed();
    int opa[10];
    int opb[10];
    opa = '{100, -100, 7, -7, -32768, 5, -5, -32768, 32767, 1};
    opb = '{7, 7, 2, 2, -1, 0, 0, -128, -128, -3};
    for (int i = 0; i < 10; i++) begin
      run_check("dir", opa[i], opb[i]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_check("rnd", rand_a(), rand_b());
    end
  endtask

  task automatic test_backpressure();
    int k, eq;
    bit eo, ed;
    model(1000, -3, eq, eo, ed);
    a        = AW'(1000);
    b        = BW'(-3);
    in_valid = 1'b1;
    k        = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    k        = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_timeout got=%b exp=1", out_valid);
    end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (int'(out) != eq || overflow !== eo || div_zero !== ed) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d got=%0d/%b%b exp=%0d/%b%b",
                 c, out, overflow, div_zero, eq, eo, ed);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hs cyc=%0d got=v%b r%b exp=v1 r0",
                 c, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release got=r%b v%b exp=r1 v0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rmc_ready_pre got=%b exp=1", in_ready);
    end
    a        = AW'(12345);
    b        = BW'(17);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out !== '0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmc_out got=%0d v%b exp=0 v0", out, out_valid);
    end
    n_cmp++;
    if (overflow !== 1'b0 || div_zero !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmc_flags got=%b%b r%b exp=00 r0",
               overflow, div_zero, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rmc_ready_post got=%b exp=1", in_ready);
    end
    run_check("rmc", 50, 5);
  endtask

  task automatic test_back_to_back();
    localparam int K = 12;
    int eq_q[$];
    bit eo_q[$];
    bit ed_q[$];
    int ra, rb, sent, got, cyc, q, eq;
    bit ov, dz, eo, ed;
    sent = 0;
    got  = 0;
    cyc  = 0;
    ra   = rand_a();
    rb   = rand_b();
    a    = AW'(ra);
    b    = BW'(rb);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (got < K && cyc < 2000) begin
      bit took;
      took = 1'b0;
      if (out_valid) begin
        if (eq_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL b2b_extra got=%0d exp=no_result", out);
        end else begin
          eq = eq_q.pop_front();
          eo = eo_q.pop_front();
          ed = ed_q.pop_front();
          q  = int'(out);
          ov = overflow;
          dz = div_zero;
          n_cmp++;
          if (q != eq || ov != eo || dz != ed) begin
            n_err++;
            $display("FAIL b2b_result idx=%0d got=%0d/%b%b exp=%0d/%b%b",
                     got, q, ov, dz, eq, eo, ed);
          end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        model(ra, rb, eq, eo, ed);
        eq_q.push_back(eq);
        eo_q.push_back(eo);
        ed_q.push_back(ed);
        sent++;
        took = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        if (sent < K) begin
          ra = rand_a();
          rb = rand_b();
          a  = AW'(ra);
          b  = BW'(rb);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (got != K || sent != K || eq_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count got=%0d sent=%0d left=%0d exp=%0d",
               got, sent, eq_q.size(), K);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_point_divider.md
FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, signed dividend width.
REQ-002 SHALL have parameter B_WIDTH, default 8, signed divisor width.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, signed quotient width.
REQ-004 SHALL have parameter IN_SCALE, default 0, left shift applied to the dividend before division, undoing the multiplier's OUT_SCALE; N = A_WIDTH+IN_SCALE.
REQ-005 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port a  input  A_WIDTH  signed dividend.
REQ-008 SHALL have port b  input  B_WIDTH  signed divisor.
REQ-009 SHALL have port in_valid  input  1  operands valid.
REQ-010 SHALL have port in_ready  output  1  divider can accept operands.
REQ-011 SHALL have port out  output  OUT_WIDTH  signed quotient.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port overflow  output  1  quotient saturated; valid with out_valid.
REQ-015 SHALL have port div_zero  output  1  divisor was zero; valid with out_valid.

Function
REQ-016 SHALL compute out = (a * 2^IN_SCALE) / b, signed, truncated toward zero.
REQ-017 SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-018 SHALL assert in_ready only in IDLE; an input transfer occurs on in_valid && in_ready.
REQ-019 SHALL, on transfer, register |a|<<IN_SCALE, |b|, and result sign = sign(a) XOR sign(b), then go to CALC; a and b are don't-care afterwards.
REQ-020 SHALL run an unsigned restoring division, one quotient bit per cycle, MSB first, N cycles in CALC, then go to DONE.
REQ-021 SHALL assert out_valid in DONE only; out_valid rises exactly N+1 rising edges after the transfer edge.
REQ-022 SHALL hold out, overflow, div_zero stable while out_valid && !out_ready.
REQ-023 SHALL return to IDLE on out_valid && out_ready; in_ready is high on the following cycle (no same-cycle result/operand overlap).
REQ-024 SHALL saturate to 2^(OUT_WIDTH-1)-1 (positive) or -2^(OUT_WIDTH-1) (negative) when the signed result does not fit, and set overflow=1.
REQ-025 SHALL, when b==0, skip CALC, enter DONE on the next edge, output max positive if a>=0 else min negative, set div_zero=1 and overflow=0.
REQ-026 SHALL handle b = -2^(B_WIDTH-1) and a = -2^(A_WIDTH-1) correctly; absolute values use one extra magnitude bit.
REQ-027 SHALL drive overflow=0 and div_zero=0 on every non-saturated, non-zero-divisor result.

Reset
REQ-028 SHALL, when rst=1 at a rising edge, enter IDLE and clear out, out_valid, overflow, div_zero and all datapath registers to 0, aborting any operation in CALC or DONE.
REQ-029 SHALL hold in_ready=0 during the reset cycle and drive it to 1 on the first edge after rst deasserts.

Configuration
REQ-030 SHALL support macro FIXED_POINT_DIVIDER_ROUND_EN: when defined, out rounds to nearest, ties away from zero (magnitude +1 when 2*remainder >= |b|) before saturation, with identical latency; when undefined, truncation toward zero per REQ-016.

Structure
REQ-031 SHALL take the FSM state enum (IDLE/CALC/DONE) and saturation limit constants from a shared package fixed_point_pkg.
REQ-032 SHALL implement one restoring step (trial subtract, select, shift) as sub-module divider_step, instantiated once and used iteratively.

Verification
REQ-033 SHALL cover a=100, b=7 -> out=14, overflow=0, div_zero=0, out_valid 17 edges after transfer; a=-100, b=7 -> out=-14.
REQ-034 SHALL cover a=7, b=2 -> out=3 without macro, out=4 with FIXED_POINT_DIVIDER_ROUND_EN; a=-7, b=2 -> -3 / -4.
REQ-035 SHALL cover a=-32768, b=-1 -> out=32767, overflow=1; a=5, b=0 -> out=32767, div_zero=1 one edge after transfer; a=-5, b=0 -> out=-32768, div_zero=1.
REQ-036 SHALL cover out_ready held low 5 cycles in DONE -> out/flags stable, in_ready=0, then release -> in_ready=1 next cycle.
REQ-037 SHALL cover rst=1 asserted mid-CALC -> all outputs 0 next edge, in_ready=1 after release, following a=50, b=5 -> out=10.
REQ-038 SHALL cover back-to-back transfers with in_valid held high -> each result correct, no operand lost or duplicated.
